// File: rtl/outerprodrc_pkg.sv
// Shared definitions for the outer-product array sequencer:
// FSM state encoding and the full bitstream length helper.
package outerprodrc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Full unary bitstream length for a sign-magnitude operand of width bw.
   function automatic int unsigned full_len(input int unsigned bw);
      return 32'd1 << (bw - 1);
   endfunction

endpackage

// File: rtl/outerprodrc_seq_if.sv
// Operand/result handshake and array drive bundle for outerprodrc_seq.
// The slave modport is the sequencer; master is the scheduler/consumer side.
interface outerprodrc_seq_if #(
   parameter int unsigned ROWNUM   = 4,
   parameter int unsigned COLNUM   = 4,
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned CNTW     = BITWIDTH
);
   logic                         iValid;
   logic                         oReady;
   logic [ROWNUM*BITWIDTH-1:0]   iData0;
   logic [COLNUM*BITWIDTH-1:0]   iData1;
   logic [CNTW-1:0]              iLen;
   logic                         iAbort;
   logic                         oArrEn;
   logic                         oArrClr;
   logic [ROWNUM*BITWIDTH-1:0]   oArrD0;
   logic [COLNUM*BITWIDTH-1:0]   oArrD1;
   logic                         oValid;
   logic                         iReady;
   logic                         oBusy;

   modport slave (
      input  iValid, iData0, iData1, iLen, iAbort, iReady,
      output oReady, oArrEn, oArrClr, oArrD0, oArrD1, oValid, oBusy
   );

   modport master (
      output iValid, iData0, iData1, iLen, iAbort, iReady,
      input  oReady, oArrEn, oArrClr, oArrD0, oArrD1, oValid, oBusy
   );
endinterface

// File: rtl/outerprodrc_runcnt.sv
// Loadable down-counter timing the array enable window.
// Priority: clear > load > decrement; terminal count flags the last enable cycle.
module outerprodrc_runcnt #(
   parameter int unsigned CNTW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clr,
   input  logic            i_load,
   input  logic [CNTW-1:0] i_ld_val,
   input  logic            i_en,
   output logic            o_tc
);
   logic [CNTW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_ld_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNTW'(1));
endmodule

// File: rtl/outerprodrc_seq.sv
// Sequencer for the unary outer-product array: accepts an operand pair, clears
// the array, enables it for L cycles, then holds the result until consumed.
module outerprodrc_seq
   import outerprodrc_pkg::*;
#(
   parameter int unsigned ROWNUM   = 4,
   parameter int unsigned COLNUM   = 4,
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned CNTW     = BITWIDTH
) (
   input logic              iClk,
   input logic              iRstN,
   outerprodrc_seq_if.slave bus
);
   localparam logic [CNTW-1:0] FULL = CNTW'(full_len(BITWIDTH));

   state_e                     r_state;
   logic                       r_ready;
   logic                       r_en;
   logic                       r_clr;
   logic                       r_valid;
   logic                       r_busy;
   logic [ROWNUM*BITWIDTH-1:0] r_d0;
   logic [COLNUM*BITWIDTH-1:0] r_d1;
   logic [CNTW-1:0]            r_len;

   logic            w_abort;
   logic [CNTW-1:0] w_len_eff;
   logic            w_cnt_clr;
   logic            w_cnt_load;
   logic            w_cnt_en;
   logic            w_tc;

   assign w_abort   = bus.iAbort && (r_state != ST_IDLE);
   assign w_len_eff = ((bus.iLen == '0) || (bus.iLen > FULL)) ? FULL : bus.iLen;

   // Counter is loaded on the CLR->RUN edge so it counts exactly the enabled cycles.
   assign w_cnt_clr  = w_abort || (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_cnt_load = (r_state == ST_CLR);
   assign w_cnt_en   = (r_state == ST_RUN);

   outerprodrc_runcnt #(.CNTW(CNTW)) u_runcnt (
      .i_clk    (iClk),
      .i_rst_n  (iRstN),
      .i_clr    (w_cnt_clr),
      .i_load   (w_cnt_load),
      .i_ld_val (r_len),
      .i_en     (w_cnt_en),
      .o_tc     (w_tc)
   );

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b1;
         r_en    <= 1'b0;
         r_clr   <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_d0    <= '0;
         r_d1    <= '0;
         r_len   <= '0;
      end else begin
         r_clr <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (bus.iValid && r_ready) begin
                  r_d0    <= bus.iData0;
                  r_d1    <= bus.iData1;
                  r_len   <= w_len_eff;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_clr   <= 1'b1;
                  r_state <= ST_CLR;
               end
            end
            ST_CLR: begin
               r_en    <= 1'b1;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_tc) begin
                  r_en    <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.iReady) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         // Abort overrides every busy-state transition, including a DONE handshake.
         if (w_abort) begin
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_clr   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
         end
      end
   end

   assign bus.oReady  = r_ready;
   assign bus.oArrEn  = r_en;
   assign bus.oArrClr = r_clr;
   assign bus.oValid  = r_valid;
   assign bus.oBusy   = r_busy;
   assign bus.oArrD0  = r_d0;
   assign bus.oArrD1  = r_d1;
endmodule

// File: tb/tb_outerprodrc_seq.sv
// Directed self-checking bench for outerprodrc_seq (ROWNUM=COLNUM=4, BITWIDTH=8).
module tb_outerprodrc_seq;
   logic clk;
   logic rst_n;
   int unsigned nvec;
   int unsigned nerr;

   outerprodrc_seq_if #(.ROWNUM(4), .COLNUM(4), .BITWIDTH(8), .CNTW(8)) bus ();

   outerprodrc_seq #(.ROWNUM(4), .COLNUM(4), .BITWIDTH(8), .CNTW(8)) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one operand pair and follow it to oValid; checks latency and enable count.
   task automatic run_op(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [7:0] len, input int unsigned exp_l);
      int unsigned en_cnt;
      int unsigned clr_cnt;
      int unsigned edges;
      logic        d_ok;
      logic        got;
      bus.iValid = 1'b1;
      bus.iData0 = d0;
      bus.iData1 = d1;
      bus.iLen   = len;
      tick();
      bus.iValid = 1'b0;
      bus.iData0 = ~d0;
      bus.iData1 = ~d1;
      chk({tag, "_clr"}, {63'd0, bus.oArrClr}, 64'd1);
      chk({tag, "_rdy0"}, {63'd0, bus.oReady}, 64'd0);
      chk({tag, "_d0"}, {32'd0, bus.oArrD0}, {32'd0, d0});
      en_cnt = 0; clr_cnt = 0; edges = 1; d_ok = 1'b1; got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         edges++;
         if (bus.oArrEn) en_cnt++;
         if (bus.oArrClr) clr_cnt++;
         if (bus.oArrD0 !== d0 || bus.oArrD1 !== d1) d_ok = 1'b0;
         if (bus.oValid) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_done"}, {63'd0, got}, 64'd1);
      chk({tag, "_encnt"}, 64'(en_cnt), 64'(exp_l));
      chk({tag, "_lat"}, 64'(edges), 64'(exp_l + 2));
      chk({tag, "_extraclr"}, 64'(clr_cnt), 64'd0);
      chk({tag, "_dstable"}, {63'd0, d_ok}, 64'd1);
      chk({tag, "_en_off"}, {63'd0, bus.oArrEn}, 64'd0);
   endtask

   task automatic consume(input string tag);
      bus.iReady = 1'b1;
      tick();
      bus.iReady = 1'b0;
      chk({tag, "_vld0"}, {63'd0, bus.oValid}, 64'd0);
      chk({tag, "_rdy1"}, {63'd0, bus.oReady}, 64'd1);
      chk({tag, "_busy0"}, {63'd0, bus.oBusy}, 64'd0);
   endtask

   initial begin
      logic ok;
      logic seen;
      nvec = 0; nerr = 0;
      rst_n = 1'b0;
      bus.iValid = 1'b0; bus.iData0 = '0; bus.iData1 = '0; bus.iLen = '0;
      bus.iAbort = 1'b0; bus.iReady = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_rdy", {63'd0, bus.oReady}, 64'd1);
      chk("rst_en", {63'd0, bus.oArrEn}, 64'd0);
      chk("rst_clr", {63'd0, bus.oArrClr}, 64'd0);
      chk("rst_vld", {63'd0, bus.oValid}, 64'd0);
      chk("rst_busy", {63'd0, bus.oBusy}, 64'd0);
      chk("rst_d", {bus.oArrD0, bus.oArrD1}, 64'd0);

      // Lengths: 0 -> full, 5, 200 -> clamped, 1, exactly full.
      run_op("full", 32'h40404040, 32'h40404040, 8'd0, 128);
      consume("full");
      run_op("len5", 32'h01020304, 32'h85868788, 8'd5, 5);
      consume("len5");
      run_op("len200", 32'hDEADBEEF, 32'h12345678, 8'd200, 128);
      consume("len200");
      run_op("len1", 32'h11111111, 32'h22222222, 8'd1, 1);
      consume("len1");
      run_op("len128", 32'hA5A5A5A5, 32'h5A5A5A5A, 8'd128, 128);
      consume("len128");

      // Backpressure in DONE with a rival iValid that must be ignored.
      run_op("bp", 32'hCAFEF00D, 32'h0BADC0DE, 8'd3, 3);
      bus.iValid = 1'b1;
      bus.iData0 = 32'h99999999;
      bus.iData1 = 32'h77777777;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!bus.oValid || bus.oArrEn || bus.oReady || bus.oArrClr ||
             bus.oArrD0 !== 32'hCAFEF00D || bus.oArrD1 !== 32'h0BADC0DE) ok = 1'b0;
      end
      chk("bp_hold", {63'd0, ok}, 64'd1);
      bus.iValid = 1'b0;
      consume("bp");

      // Abort at RUN cycle 10.
      bus.iValid = 1'b1; bus.iData0 = 32'h13579BDF; bus.iData1 = 32'h2468ACE0; bus.iLen = 8'd0;
      tick();
      bus.iValid = 1'b0;
      repeat (11) tick();
      chk("ab_running", {63'd0, bus.oArrEn}, 64'd1);
      bus.iAbort = 1'b1;
      tick();
      bus.iAbort = 1'b0;
      chk("ab_clr", {63'd0, bus.oArrClr}, 64'd1);
      chk("ab_en", {63'd0, bus.oArrEn}, 64'd0);
      chk("ab_rdy", {63'd0, bus.oReady}, 64'd1);
      chk("ab_busy", {63'd0, bus.oBusy}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 140; i++) begin
         tick();
         if (bus.oValid || bus.oArrEn || bus.oArrClr) seen = 1'b1;
      end
      chk("ab_quiet", {63'd0, seen}, 64'd0);
      run_op("after_ab", 32'h0F0F0F0F, 32'hF0F0F0F0, 8'd4, 4);
      consume("after_ab");

      // Abort and iReady together in DONE: abort wins.
      run_op("abdone", 32'h31313131, 32'h42424242, 8'd2, 2);
      bus.iAbort = 1'b1; bus.iReady = 1'b1;
      tick();
      bus.iAbort = 1'b0; bus.iReady = 1'b0;
      chk("abdone_clr", {63'd0, bus.oArrClr}, 64'd1);
      chk("abdone_vld", {63'd0, bus.oValid}, 64'd0);
      chk("abdone_rdy", {63'd0, bus.oReady}, 64'd1);
      tick();
      chk("abdone_clr_end", {63'd0, bus.oArrClr}, 64'd0);

      // iAbort in IDLE is ignored.
      bus.iAbort = 1'b1;
      tick();
      bus.iAbort = 1'b0;
      chk("idle_ab", {62'd0, bus.oArrClr, bus.oReady}, 64'd1);

      // Asynchronous reset mid-RUN, off the clock edge.
      bus.iValid = 1'b1; bus.iData0 = 32'h6B6B6B6B; bus.iData1 = 32'h7C7C7C7C; bus.iLen = 8'd50;
      tick();
      bus.iValid = 1'b0;
      repeat (5) tick();
      chk("ar_pre_en", {63'd0, bus.oArrEn}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_en", {63'd0, bus.oArrEn}, 64'd0);
      chk("ar_busy", {63'd0, bus.oBusy}, 64'd0);
      chk("ar_rdy", {63'd0, bus.oReady}, 64'd1);
      chk("ar_d", {bus.oArrD0, bus.oArrD1}, 64'd0);
      #3 rst_n = 1'b1;
      tick();
      chk("ar_idle", {62'd0, bus.oBusy, bus.oReady}, 64'd1);
      run_op("after_ar", 32'h0A0B0C0D, 32'h01010101, 8'd2, 2);
      consume("after_ar");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
